// File: rtl/vend_ctrl_pkg.sv
// Shared definitions for the vending controller: FSM state codes and coin values.
package vend_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'b00,
    ST_VEND    = 2'b01,
    ST_CHANGE  = 2'b10
  } state_e;

  localparam logic [2:0] VAL_N = 3'd1;
  localparam logic [2:0] VAL_D = 3'd2;
  localparam logic [2:0] VAL_Q = 3'd5;

endpackage

// File: rtl/vend_ctrl_coin_decode.sv
// Combinational coin strobe decoder: one-hot strobes give a value, several at once flag a bad insert.
module vend_ctrl_coin_decode
  import vend_ctrl_pkg::*;
(
  input  logic       n_i,
  input  logic       d_i,
  input  logic       q_i,
  output logic       valid_o,
  output logic [2:0] value_o,
  output logic       multi_o
);

  logic [1:0] strobeCount;

  always_comb begin
    strobeCount = {1'b0, n_i} + {1'b0, d_i} + {1'b0, q_i};
    valid_o     = (strobeCount == 2'd1);
    multi_o     = (strobeCount >= 2'd2);
    value_o     = 3'd0;
    if (valid_o) begin
      if (n_i)      value_o = VAL_N;
      else if (d_i) value_o = VAL_D;
      else          value_o = VAL_Q;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// Vending sequencer: accumulates coin credit in nickels, requests item release at the price,
// and pays change or a cancel refund back one nickel at a time.
module vend_ctrl
  import vend_ctrl_pkg::*;
#(
  parameter int PRICE_N  = 6,
  parameter int CREDIT_W = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                n_i,
  input  logic                d_i,
  input  logic                q_i,
  input  logic                cancel_i,
  input  logic                vendAck_i,
  input  logic                changeAck_i,
  output logic                vend_o,
  output logic                change_o,
  output logic                coinReject_o,
  output logic [CREDIT_W-1:0] credit_o
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_N);
  localparam logic [CREDIT_W-1:0] ONE_C   = CREDIT_W'(1);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                coinReject_q, coinReject_d;

  logic                coinValid;
  logic                coinMulti;
  logic [2:0]          coinValue;
  logic                coinAny;
  logic [CREDIT_W-1:0] creditSum;
  logic [CREDIT_W-1:0] creditAfterVend;

  vend_ctrl_coin_decode u_coinDecode (
    .n_i     (n_i),
    .d_i     (d_i),
    .q_i     (q_i),
    .valid_o (coinValid),
    .value_o (coinValue),
    .multi_o (coinMulti)
  );

  assign coinAny         = n_i | d_i | q_i;
  assign creditSum       = credit_q + CREDIT_W'(coinValue);
  assign creditAfterVend = credit_q - PRICE_C;

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    coinReject_d = 1'b0;
    unique case (state_q)
      ST_COLLECT: begin
        if (cancel_i && (credit_q != '0)) begin
          state_d      = ST_CHANGE;
          coinReject_d = coinAny;
        end else if (coinMulti) begin
          coinReject_d = 1'b1;
        end else if (coinValid) begin
          credit_d = creditSum;
          if (creditSum >= PRICE_C) state_d = ST_VEND;
        end
      end
      ST_VEND: begin
        coinReject_d = coinAny;
        if (vendAck_i) begin
          credit_d = creditAfterVend;
          state_d  = (creditAfterVend != '0) ? ST_CHANGE : ST_COLLECT;
        end
      end
      ST_CHANGE: begin
        coinReject_d = coinAny;
        // A zero credit here can only follow a corrupted state; leave without wrapping.
        if (credit_q == '0) begin
          state_d = ST_COLLECT;
        end else if (changeAck_i) begin
          credit_d = credit_q - ONE_C;
          if (credit_q == ONE_C) state_d = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_COLLECT;
      credit_q     <= '0;
      coinReject_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      coinReject_q <= coinReject_d;
    end
  end

  assign vend_o       = (state_q == ST_VEND);
  assign change_o     = (state_q == ST_CHANGE);
  assign coinReject_o = coinReject_q;
  assign credit_o     = credit_q;

endmodule
